// File: rtl/cache_axi_rd_arbiter.sv
// Arbitrates icache and dcache line refills onto one AXI4 read channel.
// Each grant issues an 8-beat 32-bit INCR burst and returns a 256-bit line.
module cache_axi_rd_arbiter #(
   parameter int              ID_W      = 4,
   parameter logic [ID_W-1:0] ICACHE_ID = ID_W'(0),
   parameter logic [ID_W-1:0] DCACHE_ID = ID_W'(1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            icache_rd_req,
   input  logic [31:0]     icache_rd_addr,
   input  logic            icache_flush,
   output logic            icache_ret_valid,
   output logic [255:0]    icache_ret_data,
   input  logic            dcache_rd_req,
   input  logic [31:0]     dcache_rd_addr,
   output logic            dcache_ret_valid,
   output logic [255:0]    dcache_ret_data,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready
);

   typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_RESP} state_t;
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t          r_state;
   state_t          w_next;
   logic            r_owner;
   logic            r_last_grant;
   logic [2:0]      r_beat_cnt;
   logic [255:0]    r_line;
   logic [255:0]    r_ret_line;
   logic            r_drop;
   logic [ID_W-1:0] r_arid;
   logic [31:0]     r_araddr;
   logic [7:0]      r_arlen;
   logic [2:0]      r_arsize;
   logic [1:0]      r_arburst;

   logic            w_ireq;
   logic            w_grant;
   logic            w_grant_d;
   logic            w_flush_own;
   logic            w_beat;
   logic            w_set_drop;
   logic [255:0]    w_line_upd;
   logic            w_unused;

   assign w_ireq      = icache_rd_req & ~icache_flush;
   assign w_flush_own = icache_flush & (r_owner == OWN_I);
   assign w_beat      = (r_state == ST_R) & rvalid;
   assign w_set_drop  = w_flush_own & (((r_state == ST_AR) & arready) | (r_state == ST_R));
   assign w_unused    = ^{rid, rresp, icache_rd_addr[4:0], dcache_rd_addr[4:0]};

   // Next-state and grant decision
   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_grant_d = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ireq && dcache_rd_req) begin
               w_grant   = 1'b1;
               w_grant_d = (r_last_grant == OWN_I);
            end else if (w_ireq) begin
               w_grant   = 1'b1;
               w_grant_d = OWN_I;
            end else if (dcache_rd_req) begin
               w_grant   = 1'b1;
               w_grant_d = OWN_D;
            end else begin
               w_grant   = 1'b0;
            end
            if (w_grant) begin
               w_next = ST_AR;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_AR: begin
            // A flush that coincides with the handshake is too late to cancel; it drops instead.
            if (arready) begin
               w_next = ST_R;
            end else if (w_flush_own) begin
               w_next = ST_IDLE;
            end else begin
               w_next = ST_AR;
            end
         end
         ST_R: begin
            if (rvalid && rlast) begin
               w_next = ST_RESP;
            end else begin
               w_next = ST_R;
            end
         end
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Merge the incoming beat into the line being assembled
   always_comb begin
      w_line_upd = r_line;
      w_line_upd[{r_beat_cnt, 5'd0} +: 32] = rdata;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Grant bookkeeping, AR fields, beat assembly and drop tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner      <= OWN_I;
         r_last_grant <= OWN_I;
         r_beat_cnt   <= 3'd0;
         r_line       <= 256'd0;
         r_ret_line   <= 256'd0;
         r_drop       <= 1'b0;
         r_arid       <= '0;
         r_araddr     <= 32'd0;
         r_arlen      <= 8'd0;
         r_arsize     <= 3'd0;
         r_arburst    <= 2'd0;
      end else begin
         if (w_grant) begin
            r_owner      <= w_grant_d;
            r_last_grant <= w_grant_d;
            r_arid       <= w_grant_d ? DCACHE_ID : ICACHE_ID;
            r_araddr     <= w_grant_d ? {dcache_rd_addr[31:5], 5'd0} : {icache_rd_addr[31:5], 5'd0};
            r_arlen      <= 8'd7;
            r_arsize     <= 3'b010;
            r_arburst    <= 2'b01;
         end
         if ((r_state == ST_AR) && arready) begin
            r_beat_cnt <= 3'd0;
         end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 3'd1;
         end
         if (w_beat) begin
            r_line <= w_line_upd;
         end
         // Snapshot on the last beat so ret_data stays stable outside RESP.
         if (w_beat && rlast) begin
            r_ret_line <= w_line_upd;
         end
         if (r_state == ST_RESP) begin
            r_drop <= 1'b0;
         end else if (w_set_drop) begin
            r_drop <= 1'b1;
         end
      end
   end

   assign arvalid          = (r_state == ST_AR);
   assign rready           = (r_state == ST_R);
   assign arid             = r_arid;
   assign araddr           = r_araddr;
   assign arlen            = r_arlen;
   assign arsize           = r_arsize;
   assign arburst          = r_arburst;
   assign icache_ret_valid = (r_state == ST_RESP) & (r_owner == OWN_I) & ~r_drop & ~icache_flush;
   assign dcache_ret_valid = (r_state == ST_RESP) & (r_owner == OWN_D) & ~r_drop;
   assign icache_ret_data  = r_ret_line;
   assign dcache_ret_data  = r_ret_line;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter: a scripted AXI slave driven at negedge,
// outputs sampled at negedge against hand-computed values.
module tb_cache_axi_rd_arbiter;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         icache_rd_req = 1'b0;
   logic [31:0]  icache_rd_addr = 32'd0;
   logic         icache_flush = 1'b0;
   logic         icache_ret_valid;
   logic [255:0] icache_ret_data;
   logic         dcache_rd_req = 1'b0;
   logic [31:0]  dcache_rd_addr = 32'd0;
   logic         dcache_ret_valid;
   logic [255:0] dcache_ret_data;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready = 1'b0;
   logic [3:0]   rid = 4'd0;
   logic [31:0]  rdata = 32'd0;
   logic [1:0]   rresp = 2'd0;
   logic         rlast = 1'b0;
   logic         rvalid = 1'b0;
   logic         rready;

   int cmp_cnt = 0;
   int err_cnt = 0;

   cache_axi_rd_arbiter #(.ID_W(4), .ICACHE_ID(4'd0), .DCACHE_ID(4'd1)) dut (
      .clk(clk), .reset(reset),
      .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr), .icache_flush(icache_flush),
      .icache_ret_valid(icache_ret_valid), .icache_ret_data(icache_ret_data),
      .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr),
      .dcache_ret_valid(dcache_ret_valid), .dcache_ret_data(dcache_ret_data),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [255:0] mk_line(input logic [31:0] base);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
      return l;
   endfunction

   task automatic send_beats(input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         rvalid = 1'b1; rdata = base + 32'(k); rlast = (k == n - 1);
         tick();
      end
      rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
   endtask

   task automatic handshake();
      arready = 1'b1;
      tick();
      arready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      cmp_cnt++; if ({arvalid, rready, icache_ret_valid, dcache_ret_valid} !== 4'b0000) begin err_cnt++; $display("FAIL reset_ctrl: got %b expected 0000", {arvalid, rready, icache_ret_valid, dcache_ret_valid}); end
      cmp_cnt++; if ({araddr, arid, arlen, arsize, arburst} !== 49'd0) begin err_cnt++; $display("FAIL reset_ar: got %h expected 0", {araddr, arid, arlen, arsize, arburst}); end
      cmp_cnt++; if (icache_ret_data !== 256'd0) begin err_cnt++; $display("FAIL reset_data: got %h expected 0", icache_ret_data); end
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_icache();
      icache_rd_req = 1'b1; icache_rd_addr = 32'h1C00_0024;
      tick();
      cmp_cnt++; if (arvalid !== 1'b1) begin err_cnt++; $display("FAIL single_arvalid: got %b expected 1", arvalid); end
      cmp_cnt++; if (araddr !== 32'h1C00_0020) begin err_cnt++; $display("FAIL single_araddr: got %h expected 1c000020", araddr); end
      cmp_cnt++; if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd7, 3'b010, 2'b01}) begin err_cnt++; $display("FAIL single_arfields: got %h expected %h", {arid, arlen, arsize, arburst}, {4'd0, 8'd7, 3'b010, 2'b01}); end
      handshake();
      cmp_cnt++; if ({arvalid, rready} !== 2'b01) begin err_cnt++; $display("FAIL single_rphase: got %b expected 01", {arvalid, rready}); end
      send_beats(8, 32'h0);
      cmp_cnt++; if ({icache_ret_valid, dcache_ret_valid} !== 2'b10) begin err_cnt++; $display("FAIL single_pulse: got %b expected 10", {icache_ret_valid, dcache_ret_valid}); end
      cmp_cnt++; if (icache_ret_data[31:0] !== 32'd0 || icache_ret_data[255:224] !== 32'd7) begin err_cnt++; $display("FAIL single_ends: got %h/%h expected 0/7", icache_ret_data[31:0], icache_ret_data[255:224]); end
      cmp_cnt++; if (icache_ret_data !== mk_line(32'h0)) begin err_cnt++; $display("FAIL single_line: got %h expected %h", icache_ret_data, mk_line(32'h0)); end
      icache_rd_req = 1'b0;
      tick();
      cmp_cnt++; if ({icache_ret_valid, arvalid, rready} !== 3'b000) begin err_cnt++; $display("FAIL single_after: got %b expected 000", {icache_ret_valid, arvalid, rready}); end
      cmp_cnt++; if (icache_ret_data !== mk_line(32'h0)) begin err_cnt++; $display("FAIL single_hold: got %h expected %h", icache_ret_data, mk_line(32'h0)); end
   endtask

   task automatic test_both();
      reset = 1'b1; tick(); reset = 1'b0; tick();
      icache_rd_req = 1'b1; icache_rd_addr = 32'h0000_1040;
      dcache_rd_req = 1'b1; dcache_rd_addr = 32'h8000_0104;
      tick();
      cmp_cnt++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h8000_0100}) begin err_cnt++; $display("FAIL both_first: got %b/%h/%h expected 1/1/80000100", arvalid, arid, araddr); end
      handshake();
      send_beats(8, 32'hD000_0000);
      cmp_cnt++; if ({icache_ret_valid, dcache_ret_valid} !== 2'b01) begin err_cnt++; $display("FAIL both_dpulse: got %b expected 01", {icache_ret_valid, dcache_ret_valid}); end
      cmp_cnt++; if (dcache_ret_data !== mk_line(32'hD000_0000)) begin err_cnt++; $display("FAIL both_dline: got %h expected %h", dcache_ret_data, mk_line(32'hD000_0000)); end
      dcache_rd_req = 1'b0;
      tick();
      cmp_cnt++; if ({icache_ret_valid, dcache_ret_valid, arvalid} !== 3'b000) begin err_cnt++; $display("FAIL both_idle: got %b expected 000", {icache_ret_valid, dcache_ret_valid, arvalid}); end
      tick();
      cmp_cnt++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h0000_1040}) begin err_cnt++; $display("FAIL both_second: got %b/%h/%h expected 1/0/00001040", arvalid, arid, araddr); end
      handshake();
      send_beats(8, 32'hA000_0000);
      cmp_cnt++; if ({icache_ret_valid, dcache_ret_valid} !== 2'b10) begin err_cnt++; $display("FAIL both_ipulse: got %b expected 10", {icache_ret_valid, dcache_ret_valid}); end
      cmp_cnt++; if (icache_ret_data !== mk_line(32'hA000_0000)) begin err_cnt++; $display("FAIL both_iline: got %h expected %h", icache_ret_data, mk_line(32'hA000_0000)); end
      icache_rd_req = 1'b0;
      tick();
      cmp_cnt++; if ({icache_ret_valid, dcache_ret_valid} !== 2'b00) begin err_cnt++; $display("FAIL both_once: got %b expected 00", {icache_ret_valid, dcache_ret_valid}); end
   endtask

   task automatic test_ar_stall();
      dcache_rd_req = 1'b1; dcache_rd_addr = 32'h0000_0ABC;
      tick();
      for (int i = 0; i < 5; i++) begin
         cmp_cnt++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h0000_0AA0}) begin err_cnt++; $display("FAIL stall_hold%0d: got %b/%h/%h expected 1/1/00000aa0", i, arvalid, arid, araddr); end
         tick();
      end
      handshake();
      cmp_cnt++; if ({arvalid, rready} !== 2'b01) begin err_cnt++; $display("FAIL stall_rphase: got %b expected 01", {arvalid, rready}); end
      send_beats(8, 32'h1234_5670);
      cmp_cnt++; if (dcache_ret_valid !== 1'b1 || dcache_ret_data !== mk_line(32'h1234_5670)) begin err_cnt++; $display("FAIL stall_done: got %b/%h expected 1/%h", dcache_ret_valid, dcache_ret_data, mk_line(32'h1234_5670)); end
      dcache_rd_req = 1'b0;
      tick();
   endtask

   task automatic test_flush_r();
      icache_rd_req = 1'b1; icache_rd_addr = 32'h2000_0000;
      tick();
      handshake();
      for (int k = 0; k < 8; k++) begin
         cmp_cnt++; if (rready !== 1'b1) begin err_cnt++; $display("FAIL flushr_rready%0d: got %b expected 1", k, rready); end
         if (k == 3) begin icache_flush = 1'b1; icache_rd_req = 1'b0; end
         else icache_flush = 1'b0;
         rvalid = 1'b1; rdata = 32'hBEEF_0000 + 32'(k); rlast = (k == 7);
         tick();
      end
      rvalid = 1'b0; rlast = 1'b0; icache_flush = 1'b0;
      cmp_cnt++; if ({icache_ret_valid, dcache_ret_valid, rready} !== 3'b000) begin err_cnt++; $display("FAIL flushr_nopulse: got %b expected 000", {icache_ret_valid, dcache_ret_valid, rready}); end
      tick();
      cmp_cnt++; if ({icache_ret_valid, arvalid, rready} !== 3'b000) begin err_cnt++; $display("FAIL flushr_idle: got %b expected 000", {icache_ret_valid, arvalid, rready}); end
      dcache_rd_req = 1'b1; dcache_rd_addr = 32'h3000_0040;
      tick();
      cmp_cnt++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h3000_0040}) begin err_cnt++; $display("FAIL flushr_dgrant: got %b/%h/%h expected 1/1/30000040", arvalid, arid, araddr); end
      handshake();
      send_beats(8, 32'h3300_0000);
      cmp_cnt++; if (dcache_ret_valid !== 1'b1 || dcache_ret_data !== mk_line(32'h3300_0000)) begin err_cnt++; $display("FAIL flushr_dline: got %b/%h expected 1/%h", dcache_ret_valid, dcache_ret_data, mk_line(32'h3300_0000)); end
      dcache_rd_req = 1'b0;
      tick();
   endtask

   task automatic test_flush_ar();
      icache_rd_req = 1'b1; icache_rd_addr = 32'h4000_0000;
      tick();
      cmp_cnt++; if (arvalid !== 1'b1) begin err_cnt++; $display("FAIL flushar_ar: got %b expected 1", arvalid); end
      icache_flush = 1'b1; icache_rd_req = 1'b0;
      tick();
      icache_flush = 1'b0;
      cmp_cnt++; if ({arvalid, rready} !== 2'b00) begin err_cnt++; $display("FAIL flushar_drop: got %b expected 00", {arvalid, rready}); end
      tick();
      cmp_cnt++; if ({arvalid, rready, icache_ret_valid} !== 3'b000) begin err_cnt++; $display("FAIL flushar_idle: got %b expected 000", {arvalid, rready, icache_ret_valid}); end
   endtask

   task automatic test_reset_mid();
      icache_rd_req = 1'b1; icache_rd_addr = 32'h6000_0000;
      tick();
      handshake();
      send_beats(5, 32'h6600_0000);
      reset = 1'b1;
      #1;
      cmp_cnt++; if ({arvalid, rready, icache_ret_valid, dcache_ret_valid} !== 4'b0000) begin err_cnt++; $display("FAIL rstmid_ctrl: got %b expected 0000", {arvalid, rready, icache_ret_valid, dcache_ret_valid}); end
      cmp_cnt++; if ({araddr, arid, arlen} !== 44'd0 || icache_ret_data !== 256'd0) begin err_cnt++; $display("FAIL rstmid_regs: got %h/%h expected 0/0", {araddr, arid, arlen}, icache_ret_data); end
      tick();
      icache_rd_addr = 32'h5000_0060;
      reset = 1'b0;
      tick();
      cmp_cnt++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h5000_0060}) begin err_cnt++; $display("FAIL rstmid_regrant: got %b/%h/%h expected 1/0/50000060", arvalid, arid, araddr); end
      handshake();
      send_beats(8, 32'h5500_0000);
      cmp_cnt++; if (icache_ret_valid !== 1'b1 || icache_ret_data !== mk_line(32'h5500_0000)) begin err_cnt++; $display("FAIL rstmid_line: got %b/%h expected 1/%h", icache_ret_valid, icache_ret_data, mk_line(32'h5500_0000)); end
      icache_rd_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_icache();
      test_both();
      test_ar_stall();
      test_flush_r();
      test_flush_ar();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule
